rename_stage: RTL and testbench

//   2-wide register-rename stage between decode and dispatch. Renames one group of up to two

---
 rtl/rename_pkg.sv | 35 +++
 rtl/rat_map_table.sv | 39 +++
 rtl/rename_stage.sv | 191 +++++++++++++++++++
 tb/tb_rename_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the 2-wide rename stage and its register alias tables.
package rename_pkg;

  localparam int ARCH_REGS    = 32;
  localparam int PHY_REGS     = 64;
  localparam int ARCH_WIDTH   = 5;
  localparam int PHY_WIDTH    = 6;
  localparam int FREE_REG     = 32;
  localparam int FL_CNT_WIDTH = $clog2(FREE_REG) + 1;
  localparam int RAT_RD_PORTS = 6;

  typedef logic [ARCH_WIDTH-1:0] arch_t;
  typedef logic [PHY_WIDTH-1:0]  phy_t;

  typedef struct packed {
    logic  valid;
    arch_t rs1;
    arch_t rs2;
    arch_t rd;
    logic  rd_we;
  } rename_in_t;

  typedef struct packed {
    logic valid;
    phy_t rs1_phy;
    phy_t rs2_phy;
    phy_t rd_phy_new;
    phy_t rd_phy_old;
  } rename_out_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rat_map_table.sv
// Architectural-to-physical map table: 6 async read ports, 2 write ports (port 1 wins),
// optional single-cycle bulk load used to restore the front map from the committed one.
module rat_map_table
  import rename_pkg::*;
#(
  parameter bit HAS_LOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  arch_t      rd_addr  [RAT_RD_PORTS],
  output phy_t       rd_data  [RAT_RD_PORTS],
  input  logic [1:0] wr_en,
  input  arch_t      wr_addr  [2],
  input  phy_t       wr_data  [2],
  input  logic       load_en,
  input  phy_t       load_map [ARCH_REGS],
  output phy_t       map      [ARCH_REGS]
);

  phy_t map_q [ARCH_REGS];

  // Reset to identity; a bulk load overrides any same-cycle writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHY_WIDTH'(i);
    end else if (HAS_LOAD && load_en) begin
      map_q <= load_map;
    end else begin
      if (wr_en[0]) map_q[wr_addr[0]] <= wr_data[0];
      if (wr_en[1]) map_q[wr_addr[1]] <= wr_data[1];
    end
  end

  always_comb begin
    for (int p = 0; p < RAT_RD_PORTS; p++) rd_data[p] = map_q[rd_addr[p]];
    for (int i = 0; i < ARCH_REGS; i++) map[i] = map_q[i];
  end

endmodule

// File: rtl/rename_stage.sv
// 2-wide rename stage: front RAT + committed RAT, freelist tag pull, registered output to dispatch.
// Define RENAME_PERF_EN to add the perf_groups / perf_fl_stall / perf_out_stall counter ports.
module rename_stage
  import rename_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [1:0]                    in_valid,
  output logic                          in_ready,
  input  logic [1:0][ARCH_WIDTH-1:0]    in_rs1,
  input  logic [1:0][ARCH_WIDTH-1:0]    in_rs2,
  input  logic [1:0][ARCH_WIDTH-1:0]    in_rd,
  input  logic [1:0]                    in_rd_we,
  output logic [1:0]                    fl_alloc,
  input  logic [PHY_WIDTH-1:0]          fl_phy_0,
  input  logic [PHY_WIDTH-1:0]          fl_phy_1,
  input  logic [FL_CNT_WIDTH-1:0]       fl_num_free,
  input  logic                          retire_valid,
  input  logic [ARCH_WIDTH-1:0]         retire_rd,
  input  logic [PHY_WIDTH-1:0]          retire_phy,
  output logic [1:0]                    out_valid,
  input  logic                          out_ready,
  output logic [1:0][PHY_WIDTH-1:0]     out_rs1_phy,
  output logic [1:0][PHY_WIDTH-1:0]     out_rs2_phy,
  output logic [1:0][PHY_WIDTH-1:0]     out_rd_phy_new,
  output logic [1:0][PHY_WIDTH-1:0]     out_rd_phy_old
`ifdef RENAME_PERF_EN
  ,
  output logic [31:0]                   perf_groups,
  output logic [31:0]                   perf_fl_stall,
  output logic [31:0]                   perf_out_stall
`endif
);

  rename_in_t  [1:0] slot;
  rename_out_t [1:0] nxt;
  rename_out_t [1:0] out_q;
  logic [1:0]        need;
  logic [1:0]        need_cnt;
  phy_t [1:0]        new_tag;
  logic              out_busy;
  logic              fl_ok;
  logic              accept;

  arch_t front_rd_addr [RAT_RD_PORTS];
  phy_t  front_rd_data [RAT_RD_PORTS];
  arch_t front_wr_addr [2];
  phy_t  front_wr_data [2];
  phy_t  front_map     [ARCH_REGS];
  arch_t commit_rd_addr [RAT_RD_PORTS];
  phy_t  commit_rd_data [RAT_RD_PORTS];
  arch_t commit_wr_addr [2];
  phy_t  commit_wr_data [2];
  phy_t  commit_map     [ARCH_REGS];
  phy_t  restore_map    [ARCH_REGS];
  logic  retire_we;

  function automatic phy_t src_phy(input arch_t rs, input phy_t rat_val, input logic byp,
                                   input arch_t byp_rd, input phy_t byp_tag);
    if (rs == '0) return '0;
    if (byp && rs == byp_rd) return byp_tag;
    return rat_val;
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      slot[k] = '{valid: in_valid[k], rs1: in_rs1[k], rs2: in_rs2[k], rd: in_rd[k], rd_we: in_rd_we[k]};
      need[k] = slot[k].valid && slot[k].rd_we && (slot[k].rd != '0);
    end
  end

  assign need_cnt  = popcount2(need);
  assign fl_ok     = fl_num_free >= FL_CNT_WIDTH'(need_cnt);
  assign out_busy  = (|out_q[0].valid || |out_q[1].valid) && !out_ready;
  assign in_ready  = !rst && !flush && !out_busy && fl_ok;
  assign accept    = (|in_valid) && in_ready;
  assign fl_alloc  = need & {2{accept}};
  assign retire_we = retire_valid && (retire_rd != '0);

  // Slot 1 takes fl_phy_1 only when slot 0 also consumed a tag; otherwise it takes the head.
  always_comb begin
    new_tag[0] = need[0] ? fl_phy_0 : '0;
    new_tag[1] = !need[1] ? '0 : (need[0] ? fl_phy_1 : fl_phy_0);
  end

  always_comb begin
    front_rd_addr[0] = slot[0].rs1;
    front_rd_addr[1] = slot[0].rs2;
    front_rd_addr[2] = slot[0].rd;
    front_rd_addr[3] = slot[1].rs1;
    front_rd_addr[4] = slot[1].rs2;
    front_rd_addr[5] = slot[1].rd;
    for (int k = 0; k < 2; k++) begin
      front_wr_addr[k] = slot[k].rd;
      front_wr_data[k] = new_tag[k];
    end
    for (int p = 0; p < RAT_RD_PORTS; p++) commit_rd_addr[p] = '0;
    commit_wr_addr[0] = retire_rd;
    commit_wr_addr[1] = '0;
    commit_wr_data[0] = retire_phy;
    commit_wr_data[1] = '0;
  end

  // Flush restore must see the retire landing in the committed map this same cycle.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) restore_map[i] = commit_map[i];
    if (retire_we) restore_map[retire_rd] = retire_phy;
  end

  always_comb begin
    nxt[0].valid      = slot[0].valid;
    nxt[0].rs1_phy    = src_phy(slot[0].rs1, front_rd_data[0], 1'b0, '0, '0);
    nxt[0].rs2_phy    = src_phy(slot[0].rs2, front_rd_data[1], 1'b0, '0, '0);
    nxt[0].rd_phy_new = new_tag[0];
    nxt[0].rd_phy_old = need[0] ? front_rd_data[2] : '0;
    nxt[1].valid      = slot[1].valid;
    nxt[1].rs1_phy    = src_phy(slot[1].rs1, front_rd_data[3], need[0], slot[0].rd, new_tag[0]);
    nxt[1].rs2_phy    = src_phy(slot[1].rs2, front_rd_data[4], need[0], slot[0].rd, new_tag[0]);
    nxt[1].rd_phy_new = new_tag[1];
    nxt[1].rd_phy_old = !need[1] ? '0 :
                        ((need[0] && slot[1].rd == slot[0].rd) ? new_tag[0] : front_rd_data[5]);
  end

  rat_map_table #(.HAS_LOAD(1'b1)) u_front_rat (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (front_rd_addr),
    .rd_data  (front_rd_data),
    .wr_en    (fl_alloc),
    .wr_addr  (front_wr_addr),
    .wr_data  (front_wr_data),
    .load_en  (flush),
    .load_map (restore_map),
    .map      (front_map)
  );

  rat_map_table #(.HAS_LOAD(1'b0)) u_commit_rat (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (commit_rd_addr),
    .rd_data  (commit_rd_data),
    .wr_en    ({1'b0, retire_we}),
    .wr_addr  (commit_wr_addr),
    .wr_data  (commit_wr_data),
    .load_en  (1'b0),
    .load_map (restore_map),
    .map      (commit_map)
  );

  // Flush beats accept and hold; an undrained output only persists while dispatch stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (flush) begin
      out_q[0].valid <= 1'b0;
      out_q[1].valid <= 1'b0;
    end else if (accept) begin
      out_q <= nxt;
    end else if (out_ready) begin
      out_q[0].valid <= 1'b0;
      out_q[1].valid <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      out_valid[k]      = out_q[k].valid;
      out_rs1_phy[k]    = out_q[k].rs1_phy;
      out_rs2_phy[k]    = out_q[k].rs2_phy;
      out_rd_phy_new[k] = out_q[k].rd_phy_new;
      out_rd_phy_old[k] = out_q[k].rd_phy_old;
    end
  end

`ifdef RENAME_PERF_EN
  // Stalls count only cycles where decode offers a group and flush is not the cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_groups    <= '0;
      perf_fl_stall  <= '0;
      perf_out_stall <= '0;
    end else begin
      if (accept) perf_groups <= perf_groups + 32'd1;
      if (|in_valid && !flush && !out_busy && !fl_ok) perf_fl_stall <= perf_fl_stall + 32'd1;
      if (|in_valid && !flush && out_busy) perf_out_stall <= perf_out_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Directed self-checking bench for rename_stage with hand-computed expected tags.
module tb_rename_stage;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic             in_ready;
  logic [1:0][4:0]  in_rs1;
  logic [1:0][4:0]  in_rs2;
  logic [1:0][4:0]  in_rd;
  logic [1:0]       in_rd_we;
  logic [1:0]       fl_alloc;
  logic [5:0]       fl_phy_0;
  logic [5:0]       fl_phy_1;
  logic [5:0]       fl_num_free;
  logic             retire_valid;
  logic [4:0]       retire_rd;
  logic [5:0]       retire_phy;
  logic [1:0]       out_valid;
  logic             out_ready;
  logic [1:0][5:0]  out_rs1_phy;
  logic [1:0][5:0]  out_rs2_phy;
  logic [1:0][5:0]  out_rd_phy_new;
  logic [1:0][5:0]  out_rd_phy_old;

  int num_compared;
  int num_mismatched;

  rename_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_rd_we       (in_rd_we),
    .fl_alloc       (fl_alloc),
    .fl_phy_0       (fl_phy_0),
    .fl_phy_1       (fl_phy_1),
    .fl_num_free    (fl_num_free),
    .retire_valid   (retire_valid),
    .retire_rd      (retire_rd),
    .retire_phy     (retire_phy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rs1_phy    (out_rs1_phy),
    .out_rs2_phy    (out_rs2_phy),
    .out_rd_phy_new (out_rd_phy_new),
    .out_rd_phy_old (out_rd_phy_old)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Packs {rs1, rs2, new, old} of one output slot into a single comparison.
  task automatic checkSlot(input string tag, input int k, input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [5:0] rd_new, input logic [5:0] rd_old);
    checkOutput(tag, {8'd0, out_rs1_phy[k], out_rs2_phy[k], out_rd_phy_new[k], out_rd_phy_old[k]},
                {8'd0, rs1, rs2, rd_new, rd_old});
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [4:0] rs1_0, input logic [4:0] rs2_0, input logic [4:0] rd_0, input logic we_0,
                               input logic [4:0] rs1_1, input logic [4:0] rs2_1, input logic [4:0] rd_1, input logic we_1);
    in_valid  = v;
    in_rs1[0] = rs1_0;  in_rs2[0] = rs2_0;  in_rd[0] = rd_0;  in_rd_we[0] = we_0;
    in_rs1[1] = rs1_1;  in_rs2[1] = rs2_1;  in_rd[1] = rd_1;  in_rd_we[1] = we_1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst = 1'b1;  flush = 1'b0;  out_ready = 1'b1;
    fl_phy_0 = '0;  fl_phy_1 = '0;  fl_num_free = 6'd32;
    retire_valid = 1'b0;  retire_rd = '0;  retire_phy = '0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset fl_alloc", 32'(fl_alloc), 32'd0);
    checkOutput("reset out_rd_phy_new", 32'(out_rd_phy_new), 32'd0);
    rst = 1'b0;

    // add x1,x2,x3 ; add x4,x1,x1
    applyStimulus(2'b11, 2, 3, 1, 1, 1, 1, 4, 1);
    fl_phy_0 = 6'd32;  fl_phy_1 = 6'd33;
    #1;
    checkOutput("g1 in_ready", 32'(in_ready), 32'd1);
    checkOutput("g1 fl_alloc", 32'(fl_alloc), 32'b11);
    stepClock();
    checkOutput("g1 out_valid", 32'(out_valid), 32'b11);
    checkSlot("g1 slot0", 0, 2, 3, 32, 1);
    checkSlot("g1 slot1", 1, 32, 32, 33, 4);

    // Both slots write x5; slot 1 also reads x5
    @(negedge clk);
    applyStimulus(2'b11, 0, 0, 5, 1, 5, 0, 5, 1);
    fl_phy_0 = 6'd40;  fl_phy_1 = 6'd41;
    stepClock();
    checkSlot("same rd slot0", 0, 0, 0, 40, 5);
    checkSlot("same rd slot1", 1, 40, 0, 41, 40);

    // Read x5 with rd=x0: no allocation
    @(negedge clk);
    applyStimulus(2'b01, 5, 5, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("x0 rd fl_alloc", 32'(fl_alloc), 32'd0);
    stepClock();
    checkOutput("read x5 out_valid", 32'(out_valid), 32'b01);
    checkSlot("read x5 slot0", 0, 41, 41, 0, 0);

    // Freelist has one entry but two slots allocate
    @(negedge clk);
    applyStimulus(2'b11, 0, 0, 9, 1, 0, 0, 10, 1);
    fl_phy_0 = 6'd42;  fl_phy_1 = 6'd43;  fl_num_free = 6'd1;
    #1;
    checkOutput("fl low in_ready", 32'(in_ready), 32'd0);
    checkOutput("fl low fl_alloc", 32'(fl_alloc), 32'd0);
    stepClock();
    checkOutput("fl low out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    fl_num_free = 6'd2;
    #1;
    checkOutput("fl ok in_ready", 32'(in_ready), 32'd1);
    checkOutput("fl ok fl_alloc", 32'(fl_alloc), 32'b11);
    stepClock();
    checkOutput("fl ok out_valid", 32'(out_valid), 32'b11);
    checkSlot("fl ok slot0", 0, 0, 0, 42, 9);
    checkSlot("fl ok slot1", 1, 0, 0, 43, 10);
    fl_num_free = 6'd32;

    // Dispatch stalls for three cycles
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(2'b11, 0, 0, 11, 1, 0, 0, 12, 1);
    fl_phy_0 = 6'd44;  fl_phy_1 = 6'd45;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      stepClock();
      checkOutput("stall out_valid", 32'(out_valid), 32'b11);
      checkOutput("stall out_rd_phy_new", 32'(out_rd_phy_new), {20'd0, 6'd43, 6'd42});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    stepClock();
    checkSlot("release slot0", 0, 0, 0, 44, 11);
    checkSlot("release slot1", 1, 0, 0, 45, 12);

    // x7 -> 50, retire it, x7 -> 51, then flush with retire x8 -> 52
    @(negedge clk);
    applyStimulus(2'b01, 0, 0, 7, 1, 0, 0, 0, 0);
    fl_phy_0 = 6'd50;  fl_phy_1 = 6'd51;
    stepClock();
    checkSlot("x7 to 50", 0, 0, 0, 50, 7);
    @(negedge clk);
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    retire_valid = 1'b1;  retire_rd = 5'd7;  retire_phy = 6'd50;
    stepClock();
    @(negedge clk);
    retire_valid = 1'b0;
    applyStimulus(2'b01, 0, 0, 7, 1, 0, 0, 0, 0);
    fl_phy_0 = 6'd51;  fl_phy_1 = 6'd52;
    stepClock();
    checkSlot("x7 to 51", 0, 0, 0, 51, 50);
    @(negedge clk);
    flush = 1'b1;  out_ready = 1'b0;
    retire_valid = 1'b1;  retire_rd = 5'd8;  retire_phy = 6'd52;
    applyStimulus(2'b01, 0, 0, 9, 1, 0, 0, 0, 0);
    #1;
    checkOutput("flush in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush fl_alloc", 32'(fl_alloc), 32'd0);
    stepClock();
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;  out_ready = 1'b1;  retire_valid = 1'b0;
    applyStimulus(2'b11, 7, 8, 0, 0, 8, 7, 0, 0);
    stepClock();
    checkOutput("post flush out_valid", 32'(out_valid), 32'b11);
    checkSlot("post flush slot0", 0, 50, 52, 0, 0);
    checkSlot("post flush slot1", 1, 52, 50, 0, 0);

    // Reset while a full group is held in the output register
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(2'b11, 0, 0, 13, 1, 0, 0, 14, 1);
    fl_phy_0 = 6'd60;  fl_phy_1 = 6'd61;
    stepClock();
    checkOutput("pre reset out_valid", 32'(out_valid), 32'b11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;  out_ready = 1'b1;
    applyStimulus(2'b11, 13, 14, 0, 0, 7, 1, 0, 0);
    stepClock();
    checkSlot("identity slot0", 0, 13, 14, 0, 0);
    checkSlot("identity slot1", 1, 7, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
